// File: rtl/sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_arbiter
// Brief    : Two-requester round-robin arbiter and zero-fill initialiser for
//            one single-port RAM with a 1-cycle registered read. Read data is
//            steered back to the requester that issued the read.
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // requester 0
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  // requester 1
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  // RAM side
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  // status
  output logic                  init_done
);

  localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_ptr;          // requester favoured on contention
  logic                  r_rsp_pending;
  logic                  r_rsp_id;
  logic                  r_init_done;
  logic                  w_grant0;
  logic                  w_grant1;

  // Round-robin grant: a lone requester always wins, the pointer breaks ties.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (r_state == ST_RUN) begin
      w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
      w_grant1 = req1_valid & (~req0_valid |  r_ptr);
    end
  end

  // Next-state decode and RAM port mux; idle leaves every RAM output at zero.
  always_comb begin
    w_state_next = r_state;
    ram_ce       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_data     = '0;
    if (r_state == ST_INIT) begin
      ram_ce   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = r_cnt;
      if (r_cnt == C_LAST_ADDR) begin
        w_state_next = ST_RUN;
      end
    end else if (w_grant0) begin
      ram_ce   = 1'b1;
      ram_we   = req0_we;
      ram_addr = req0_addr;
      ram_data = req0_wdata;
    end else if (w_grant1) begin
      ram_ce   = 1'b1;
      ram_we   = req1_we;
      ram_addr = req1_addr;
      ram_data = req1_wdata;
    end
  end

  // State, fill counter, pointer and read-response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_cnt         <= '0;
      r_ptr         <= 1'b0;
      r_rsp_pending <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_init_done   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_init_done <= (w_state_next == ST_RUN);
      // the counter parks on the last address rather than wrapping
      if (r_state == ST_INIT && r_cnt != C_LAST_ADDR) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_grant0) begin
        r_ptr <= 1'b1;
      end else if (w_grant1) begin
        r_ptr <= 1'b0;
      end
      r_rsp_pending <= (w_grant0 & ~req0_we) | (w_grant1 & ~req1_we);
      r_rsp_id      <= w_grant1;
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign init_done  = r_init_done;

  // ram_q is only meaningful in the cycle after a read, so it is masked otherwise.
  assign rsp0_valid = r_rsp_pending & ~r_rsp_id;
  assign rsp1_valid = r_rsp_pending &  r_rsp_id;
  assign rsp0_data  = rsp0_valid ? ram_q : '0;
  assign rsp1_data  = rsp1_valid ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_arbiter
// Brief    : Directed self-checking bench for sp_ram_arbiter with a
//            behavioural single-port RAM (1-cycle registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_arbiter;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_we, req0_ready, rsp0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, rsp0_data;
  logic          req1_valid, req1_we, req1_ready, rsp1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, rsp1_data;
  logic          ram_ce, ram_we, init_done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, ram_q;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [DEPTH];

  sp_ram_arbiter #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_q(ram_q), .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural single-port RAM, registered read
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        ram_q <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic v1, input logic we1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  initial begin
    rst_n = 1'b0;
    // requests held valid through reset/init: readys must stay low anyway
    drive(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00);
    #3;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_rsp0_data", rsp0_data, 0);
    chk("rst_ram_ce", ram_ce, 1);
    chk("rst_ram_we", ram_we, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_init_done", init_done, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // zero-fill: 16 cycles of writes, readys low
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("init_ready0", req0_ready, 0);
      chk("init_ready1", req1_ready, 0);
      chk("init_addr", ram_addr, i);
      chk("init_we", ram_we, 1);
      chk("init_done_low", init_done, 0);
      tick();
    end
    chk("init_done_high", init_done, 1);

    // every address reads back zero
    for (int a = 0; a < DEPTH; a++) begin
      drive(1, 0, AW'(a), 8'h00, 0, 0, 4'd0, 8'h00);
      #1;
      chk("zr_ready0", req0_ready, 1);
      chk("zr_ready1", req1_ready, 0);
      tick();
      chk("zr_rsp0_valid", rsp0_valid, 1);
      chk("zr_rsp0_data", rsp0_data, 0);
      chk("zr_rsp1_valid", rsp1_valid, 0);
    end

    // idle: RAM port quiet
    drive(0, 1, 4'd5, 8'hFF, 0, 1, 4'd6, 8'hEE);
    #1;
    chk("idle_ce", ram_ce, 0);
    chk("idle_we", ram_we, 0);
    chk("idle_addr", ram_addr, 0);
    chk("idle_data", ram_data, 0);
    chk("idle_ready0", req0_ready, 0);
    tick();
    chk("idle_rsp0_valid", rsp0_valid, 0);

    // single requester: write 0xA5 to 3, read it back
    drive(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
    #1;
    chk("wr_ready0", req0_ready, 1);
    chk("wr_ram_we", ram_we, 1);
    chk("wr_ram_data", ram_data, 8'hA5);
    tick();
    chk("wr_no_rsp0", rsp0_valid, 0);
    drive(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    #1;
    chk("rd_ram_we", ram_we, 0);
    tick();
    drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    chk("rd_rsp0_valid", rsp0_valid, 1);
    chk("rd_rsp0_data", rsp0_data, 8'hA5);
    chk("rd_rsp1_valid", rsp1_valid, 0);
    tick();
    chk("rd_rsp0_pulse_end", rsp0_valid, 0);

    // read-after-write across requesters
    drive(0, 0, 4'd0, 8'h00, 1, 1, 4'd15, 8'h3C);
    #1;
    chk("raw_wr_ready1", req1_ready, 1);
    tick();
    drive(1, 0, 4'd15, 8'h00, 0, 0, 4'd0, 8'h00);
    #1;
    chk("raw_rd_ready0", req0_ready, 1);
    tick();
    chk("raw_rsp0_valid", rsp0_valid, 1);
    chk("raw_rsp0_data", rsp0_data, 8'h3C);
    drive(0, 0, 4'd0, 8'h00, 1, 1, 4'd7, 8'h77);
    #1;
    chk("wr7_ready1", req1_ready, 1);
    tick();

    // req1 alone for two cycles, then both valid: req0 first, then alternate
    drive(0, 0, 4'd0, 8'h00, 1, 0, 4'd7, 8'h00);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("solo1_ready1", req1_ready, 1);
      tick();
      chk("solo1_rsp1_valid", rsp1_valid, 1);
      chk("solo1_rsp1_data", rsp1_data, 8'h77);
      chk("solo1_rsp0_valid", rsp0_valid, 0);
    end
    drive(1, 0, 4'd3, 8'h00, 1, 0, 4'd7, 8'h00);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("cont_ready0", req0_ready, (c % 2 == 0) ? 1 : 0);
      chk("cont_ready1", req1_ready, (c % 2 == 1) ? 1 : 0);
      tick();
      chk("cont_rsp0_valid", rsp0_valid, (c % 2 == 0) ? 1 : 0);
      chk("cont_rsp1_valid", rsp1_valid, (c % 2 == 1) ? 1 : 0);
      chk("cont_rsp0_data", rsp0_data, (c % 2 == 0) ? 8'hA5 : 8'h00);
      chk("cont_rsp1_data", rsp1_data, (c % 2 == 1) ? 8'h77 : 8'h00);
    end

    // reset right after a read accept: response dropped, fill repeats
    drive(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    #1;
    chk("mr_ready0", req0_ready, 1);
    tick();
    rst_n = 1'b0;
    drive(1, 0, 4'd3, 8'h00, 1, 0, 4'd7, 8'h00);
    #1;
    chk("mr_rsp0_valid", rsp0_valid, 0);
    chk("mr_rsp0_data", rsp0_data, 0);
    chk("mr_init_done", init_done, 0);
    chk("mr_ram_ce", ram_ce, 1);
    chk("mr_ram_addr", ram_addr, 0);
    chk("mr_ready0", req0_ready, 0);
    tick();
    chk("mr_rsp0_valid_hold", rsp0_valid, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("refill_ready0", req0_ready, 0);
      chk("refill_ready1", req1_ready, 0);
      chk("refill_done_low", init_done, 0);
      tick();
    end
    chk("refill_done_high", init_done, 1);
    drive(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
    #1;
    tick();
    chk("clr3_rsp0_valid", rsp0_valid, 1);
    chk("clr3_rsp0_data", rsp0_data, 0);
    drive(0, 0, 4'd0, 8'h00, 1, 0, 4'd15, 8'h00);
    #1;
    chk("clr15_ready1", req1_ready, 1);
    tick();
    chk("clr15_rsp1_valid", rsp1_valid, 1);
    chk("clr15_rsp1_data", rsp1_data, 0);
    chk("clr15_rsp0_valid", rsp0_valid, 0);
    drive(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-requester round-robin arbiter and initialiser for one `sp_ram` instance (1-cycle registered read). After reset it zero-fills the RAM. It then grants one valid/ready request per cycle and routes the read data back to the requester that issued the read. It sits between two datapath clients, for example a weight loader and a compute engine, and the single shared SRAM macro.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must match the RAM.
- RAM_DEPTH, 16, number of words; must be ≥2.
- ADDR_WIDTH, $clog2(RAM_DEPTH), address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_WIDTH  word address.
- req0_wdata / req1_wdata  in  DATA_WIDTH  write data.
- req0_ready / req1_ready  out  1  request accepted this cycle when valid && ready.
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse; read data valid.
- rsp0_data / rsp1_data  out  DATA_WIDTH  read data; 0 when the matching rsp_valid is low.
- ram_ce, ram_we  out  1  RAM enables.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data  out  DATA_WIDTH  RAM write data.
- ram_q  in  DATA_WIDTH  RAM read data, valid the cycle after a ce.
- init_done  out  1  high once zero-fill has completed.

## Operation
- FSM states: INIT, RUN.
- Reset enters INIT. Init address counter = 0. Priority pointer = 0.
- INIT:
  - Every cycle drives ram_ce=1, ram_we=1, ram_addr=counter, ram_data=0.
  - Counter increments each cycle.
  - After writing address RAM_DEPTH-1, moves to RUN.
  - Both readys are held low for the whole state.
  - No wrap: the counter stops and the state changes.
- RUN arbitration (combinational from valids and pointer):
  - Neither valid: no grant, ram_ce=0.
  - Exactly one valid: that requester is granted.
  - Both valid: the requester named by the pointer is granted.
- Grant effects:
  - reqN_ready=1 for the granted requester only.
  - ram_ce=1; ram_we, ram_addr, ram_data are muxed from the winner.
  - Pointer updates to the non-granted index.
  - With no grant, the pointer holds.
- readys depend on the valids, so requesters must not make valid depend on ready.
- Read response:
  - A granted read registers rsp_pending=1 and rsp_id=N.
  - Next cycle: rspN_valid=1 and rspN_data=ram_q; the other rsp outputs are 0.
  - No backpressure on responses.
- Writes produce no response.
- ram_we=0 whenever ram_ce=0. ram_addr and ram_data are 0 when idle.

## Timing
- Reset values:
  - All ready and rsp_valid = 0; rsp_data = 0.
  - ram_ce=1, ram_we=1, ram_addr=0, ram_data=0 (INIT drives the first fill write combinationally).
  - init_done = 0.
- Zero-fill occupies RAM_DEPTH cycles after rst_n deasserts.
- init_done rises on the edge that enters RUN. The first grant is possible in that cycle.
- Throughput: one access per cycle, shared between both requesters.
- Read latency: accept at edge k → rsp_valid high during cycle k+1, for exactly 1 cycle.
- Back-to-back reads by alternating requesters give alternating rsp pulses on consecutive cycles.
- Read-after-write:
  - A write accepted at edge k followed by a read of the same address accepted at edge k+1 returns the new data.
  - No same-cycle read/write hazard exists, since there is one grant per cycle.
- Starvation bound: a continuously valid requester is granted within 2 cycles.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronous).
  - A pending response is dropped.
  - The zero-fill restarts after release.

## Test plan
- Reset/init (DATA_WIDTH=8, RAM_DEPTH=16):
  - Release rst_n; readys stay 0 for 16 cycles; init_done rises after 16 cycles.
  - Reading addresses 0..15 afterwards returns 0x00.
- Single requester: req0 writes 0xA5 to address 3, then reads address 3 → rsp0_valid pulses 1 cycle after the read accept with rsp0_data=0xA5; rsp1_valid stays 0.
- Contention:
  - Both valid and reading for 6 cycles → grants alternate 0,1,0,1,0,1.
  - Responses alternate on consecutive cycles with the correct data per requester.
- Pointer update: only req1 valid for 2 cycles, then both valid → req0 granted first.
- Read-after-write: req1 writes 0x3C to address 15 at edge k; req0 reads address 15 at edge k+1 → rsp0_data=0x3C at cycle k+2.
- Reset mid-read: assert rst_n=0 the cycle after a read is accepted → no rsp_valid pulse; full zero-fill repeats; earlier data is cleared to 0.
